// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer in front of the UART transmit path.
// Software queues bytes on the valid/ready write port. The sequencer hands them
// to the transmit path one at a time. It uses the path's busy signal to know when
// a frame has started and when it has finished.
// Optional build macro UART_TX_FIFO_LEVEL_EN adds two outputs: level_o (the
// current fill count) and a sticky overflow_o flag.
//
// state        | meaning
// ------------ | ----------------------------------------------------------
// ST_IDLE      | nothing in flight; launch when data is queued and path not busy
// ST_LAUNCH    | tx_en_o is high for this single cycle
// ST_WAIT_START| waiting for the path to raise busy (no timeout)
// ST_WAIT_DONE | frame on the line; waiting for busy to fall
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              flush_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              idle_o,
`ifdef UART_TX_FIFO_LEVEL_EN
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o,
`endif
  output logic [7:0]        tx_data_o,
  output logic              tx_en_o,
  input  logic              tx_bussy_i
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic              push, launch;

  assign full_o     = (count_q == DEPTH_CNT);
  assign empty_o    = (count_q == '0);
  assign wr_ready_o = !full_o;
  assign idle_o     = empty_o && (state_q == ST_IDLE) && !tx_bussy_i;
  assign tx_data_o  = tx_data_q;
  assign tx_en_o    = tx_en_q;

  // Flush beats both sides. A launch that coincides with a flush is suppressed,
  // so the transmit path never sees a byte the FIFO has already discarded.
  assign push   = wr_valid_i && !full_o && !flush_i;
  assign launch = (state_q == ST_IDLE) && !empty_o && !tx_bussy_i && !flush_i;

  // Pointer and occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (launch) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, launch})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write: only an accepted push touches the RAM.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data_i;
  end

  // Sequencer next state.
  // tx_data holds the last launched byte; tx_en is a one-cycle strobe.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_en_d   = 1'b1;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH:     state_d = ST_WAIT_START;
      ST_WAIT_START: if (tx_bussy_i)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE:  if (!tx_bussy_i) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
    end
  end

  // RAM contents need no reset; the count and pointers gate every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  logic overflow_q, overflow_d;

  assign level_o    = count_q;
  assign overflow_o = overflow_q;

  // Sticky overflow flag: a write attempt while full sets it; a flush clears it.
  always_comb begin
    overflow_d = overflow_q;
    if (flush_i)                   overflow_d = 1'b0;
    else if (wr_valid_i && full_o) overflow_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with DEPTH=4.
// The transmit path is modelled as follows: busy rises the cycle after an
// enable and stays high for 20 cycles.
module tb_uart_tx_fifo;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] wr_data_i = 8'h00;
  logic wr_valid_i = 1'b0;
  logic flush_i = 1'b0;
  logic wr_ready_o, full_o, empty_o, idle_o, tx_en_o, tx_bussy_i;
  logic [7:0] tx_data_o;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [ADDR_W:0] level_o;
  logic overflow_o;
`endif

  uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .flush_i(flush_i), .full_o(full_o), .empty_o(empty_o), .idle_o(idle_o),
`ifdef UART_TX_FIFO_LEVEL_EN
    .level_o(level_o), .overflow_o(overflow_o),
`endif
    .tx_data_o(tx_data_o), .tx_en_o(tx_en_o), .tx_bussy_i(tx_bussy_i)
  );

  always #5 clk_i = ~clk_i;

  // Transmit path model. It is not reset, so a frame in progress finishes across a FIFO reset.
  int busy_cnt = 0;
  assign tx_bussy_i = (busy_cnt != 0);
  always @(posedge clk_i) begin
    if (tx_en_o)            busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  logic [7:0] mon_exp;

  // Scoreboard: each enable pulse must carry the oldest outstanding byte and
  // must never coincide with busy.
  always @(posedge clk_i) begin
    if (!rst_i && tx_en_o) begin
      en_cnt++;
      total++;
      if (tx_bussy_i !== 1'b0) begin
        bad++;
        $display("FAIL en_while_busy: busy=%b required 0", tx_bussy_i);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_en: data=%h, no byte outstanding", tx_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data_o !== mon_exp) begin
          bad++;
          $display("FAIL tx_data_order: got %h required %h", tx_data_o, mon_exp);
        end
      end
    end
  end

  // Hold a write until it is accepted. Called at a negedge; returns at a negedge.
  task automatic write_byte(input logic [7:0] d, input int limit, output bit ok);
    ok = 1'b0;
    wr_data_i = d;
    wr_valid_i = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (wr_ready_o) begin
        exp_q.push_back(d);
        ok = 1'b1;
        @(negedge clk_i);
        break;
      end
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0;
  endtask

  // Wait until every queued byte has gone out and the path is idle.
  task automatic wait_drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (idle_o && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    total++;
    if (empty_o !== 1'b1 || full_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags: empty=%b full=%b ready=%b required 1 0 1", empty_o, full_o, wr_ready_o);
    end
    total++;
    if (tx_en_o !== 1'b0 || tx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_tx: en=%b data=%h required 0 00", tx_en_o, tx_data_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (idle_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle: idle=%b required 1", idle_o);
    end
  endtask

  task automatic test_reset_mid_stream();
    bit ok;
    bit saw_en;
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h31 + 8'(i), 50, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL rst_mid_write: byte %0d not accepted", i);
      end
    end
    for (int i = 0; i < 20 && !tx_bussy_i; i++) @(negedge clk_i);
    total++;
    if (tx_bussy_i !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_busy: busy=%b required 1", tx_bussy_i);
    end
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    total++;
    if (empty_o !== 1'b1 || tx_en_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_state: empty=%b en=%b ready=%b required 1 0 1", empty_o, tx_en_o, wr_ready_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    write_byte(8'h3A, 10, ok);
    saw_en = 1'b0;
    for (int i = 0; i < 40 && tx_bussy_i; i++) begin
      if (tx_en_o) saw_en = 1'b1;
      @(negedge clk_i);
    end
    total++;
    if (saw_en || tx_bussy_i || !ok) begin
      bad++;
      $display("FAIL rst_mid_no_launch: en_seen=%b busy=%b accepted=%b required 0 0 1", saw_en, tx_bussy_i, ok);
    end
    wait_drain(100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rst_mid_drain: timeout, outstanding=%0d", exp_q.size());
    end
  endtask

  task automatic test_latency();
    bit ok;
    wr_data_i = 8'hA5;
    wr_valid_i = 1'b1;
    total++;
    if (wr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL lat_ready: ready=%b required 1", wr_ready_o);
    end
    exp_q.push_back(8'hA5);
    @(negedge clk_i);
    wr_valid_i = 1'b0;
    total++;
    if (tx_en_o !== 1'b0) begin
      bad++;
      $display("FAIL lat_n1: en=%b required 0", tx_en_o);
    end
    @(negedge clk_i);
    total++;
    if (tx_en_o !== 1'b1 || tx_data_o !== 8'hA5) begin
      bad++;
      $display("FAIL lat_n2: en=%b data=%h required 1 a5", tx_en_o, tx_data_o);
    end
    @(negedge clk_i);
    total++;
    if (tx_en_o !== 1'b0) begin
      bad++;
      $display("FAIL lat_pulse: en=%b required 0", tx_en_o);
    end
    wait_drain(60, ok);
    total++;
    if (!ok || idle_o !== 1'b1) begin
      bad++;
      $display("FAIL lat_idle: idle=%b required 1", idle_o);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int en0;
    en0 = en_cnt;
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i), 100, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL b2b_write: byte %0d not accepted", i);
      end
    end
    wait_drain(300, ok);
    total++;
    if (!ok || en_cnt - en0 != 5) begin
      bad++;
      $display("FAIL b2b_count: drained=%b enables=%0d required 5", ok, en_cnt - en0);
    end
  endtask

  task automatic test_full();
    bit ok;
    for (int i = 0; i < 5; i++) begin
      write_byte(8'h21 + 8'(i), 50, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL full_fill: byte %0d not accepted", i);
      end
    end
    wr_data_i = 8'h99;
    wr_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (full_o !== 1'b1 || wr_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL full_block: full=%b ready=%b required 1 0", full_o, wr_ready_o);
      end
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0;
`ifdef UART_TX_FIFO_LEVEL_EN
    total++;
    if (level_o !== 3'd4 || overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL full_level: level=%0d ovf=%b required 4 1", level_o, overflow_o);
    end
`endif
    flush_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    flush_i = 1'b0;
    total++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      bad++;
      $display("FAIL full_flush: empty=%b full=%b required 1 0", empty_o, full_o);
    end
`ifdef UART_TX_FIFO_LEVEL_EN
    total++;
    if (overflow_o !== 1'b0 || level_o !== 3'd0) begin
      bad++;
      $display("FAIL full_ovf_clear: ovf=%b level=%0d required 0 0", overflow_o, level_o);
    end
`endif
    wait_drain(100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL full_drain: timeout");
    end
  endtask

  task automatic test_flush_inflight();
    bit ok;
    int en0;
    write_byte(8'h10, 20, ok);
    for (int i = 0; i < 10 && !tx_bussy_i; i++) @(negedge clk_i);
    write_byte(8'h33, 20, ok);
    total++;
    if (!ok || tx_bussy_i !== 1'b1) begin
      bad++;
      $display("FAIL flush_setup: accepted=%b busy=%b required 1 1", ok, tx_bussy_i);
    end
    en0 = en_cnt;
    flush_i = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i = 8'h77;
    exp_q.delete();
    @(negedge clk_i);
    flush_i = 1'b0;
    wr_valid_i = 1'b0;
    total++;
    if (empty_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_empty: empty=%b required 1", empty_o);
    end
    wait_drain(60, ok);
    total++;
    if (!ok || en_cnt != en0 || tx_data_o !== 8'h10) begin
      bad++;
      $display("FAIL flush_inflight: drained=%b new_en=%0d data=%h required 1 0 10", ok, en_cnt - en0, tx_data_o);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int model;
    int gap;
    int bad0;
    bad0 = bad;
    for (int i = 0; i < 9; i++) begin
      gap = $urandom_range(0, 6);
      ok = 1'b0;
      for (int c = 0; c < gap + 200 && !ok; c++) begin
        model = exp_q.size() - (tx_en_o ? 1 : 0);
        total++;
        if (model > DEPTH || full_o !== (model == DEPTH) || empty_o !== (model == 0)) begin
          bad++;
          $display("FAIL wrap_count: model=%0d full=%b empty=%b", model, full_o, empty_o);
        end
        if (c >= gap) begin
          wr_data_i = 8'h50 + 8'(i);
          wr_valid_i = 1'b1;
          if (wr_ready_o) begin
            exp_q.push_back(8'h50 + 8'(i));
            ok = 1'b1;
          end
        end
        @(negedge clk_i);
        wr_valid_i = 1'b0;
      end
      if (!ok) begin
        bad++;
        $display("FAIL wrap_write: byte %0d not accepted", i);
      end
    end
    wait_drain(400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wrap_drain: timeout, outstanding=%0d", exp_q.size());
    end
    if (bad != bad0) $display("wrap test saw %0d errors", bad - bad0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_stream();
    test_latency();
    test_back_to_back();
    test_full();
    test_flush_inflight();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
